// File: rtl/iob_cache_perf_ctrl.sv
// ----------------------------------------------------------------------------
// iob_cache_perf_ctrl
//   CSR block for cache performance counters and cache invalidation control.
//
//   Word map (word index = addr_i[ADDR_W-1:2]):
//     0 HIT (READ_HIT+WRITE_HIT)    1 MISS (READ_MISS+WRITE_MISS)
//     2 READ_HIT   3 READ_MISS   4 WRITE_HIT   5 WRITE_MISS
//     6 CTRL   bit0 cnt_en (rw), bit1 clear (self-clearing), bit2 invalidate
//     7 STATUS bit0 wtbuf_empty, bit1 wtbuf_full, bit2 inval_busy, bit3 sat
//     8 VERSION
//     others read 0, writes ignored.
//
//   Handshake: a request is sampled on any enabled edge with valid_i=1 and
//   acknowledged by ready_o=1 during the following enabled cycle; rdata_o
//   carries the read word in that cycle and is 0 otherwise. There is no
//   back-pressure, so back-to-back requests each get their own ready pulse.
//
//   Ports:
//     clk_i, cke_i, rst_i             clock, clock enable, sync reset
//     valid_i, addr_i, wdata_i, wstrb_i  CSR request (wstrb_i==0 is a read)
//     read_hit_i .. write_miss_i      single-cycle event strobes
//     wtbuf_full_i, wtbuf_empty_i     write-through buffer status
//     invalidate_done_i               invalidation complete
//     rdata_o, ready_o                CSR response
//     invalidate_o                    invalidate request level
//     inval_busy_o                    invalidation FSM state (1 = BUSY)
// ----------------------------------------------------------------------------
module iob_cache_perf_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 6,
  parameter int CNT_W        = 32,
  parameter bit SATURATE     = 1'b0,
  parameter bit USE_CTRL_CNT = 1'b1
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                read_hit_i,
  input  logic                read_miss_i,
  input  logic                write_hit_i,
  input  logic                write_miss_i,
  input  logic                wtbuf_full_i,
  input  logic                wtbuf_empty_i,
  input  logic                invalidate_done_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                invalidate_o,
  output logic                inval_busy_o
);

  localparam int WORD_W = ADDR_W - 2;

  localparam logic [WORD_W-1:0] W_HIT        = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_MISS       = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_READ_HIT   = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_READ_MISS  = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_WRITE_HIT  = WORD_W'(4);
  localparam logic [WORD_W-1:0] W_WRITE_MISS = WORD_W'(5);
  localparam logic [WORD_W-1:0] W_CTRL       = WORD_W'(6);
  localparam logic [WORD_W-1:0] W_STATUS     = WORD_W'(7);
  localparam logic [WORD_W-1:0] W_VERSION    = WORD_W'(8);

  localparam logic [DATA_W-1:0] CSR_VERSION = DATA_W'(16'h0100);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } inval_state_t;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] word;
  logic              is_write;
  logic              ctrl_wr;
  logic              cnt_clr;
  logic              inval_req;

  assign word      = addr_i[ADDR_W-1:2];
  assign is_write  = |wstrb_i;
  // CTRL only lives in byte 0, so a write without that lane is not a CTRL write.
  assign ctrl_wr   = valid_i && is_write && (word == W_CTRL) && wstrb_i[0];
  assign cnt_clr   = ctrl_wr && wdata_i[1];
  assign inval_req = ctrl_wr && wdata_i[2];

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i[DATA_W-1:3]};

  // --------------------------------------------------------------------------
  // Event counters
  // --------------------------------------------------------------------------
  logic             cnt_en;
  logic             sat_flag;
  logic [CNT_W-1:0] hit_val;
  logic [CNT_W-1:0] miss_val;
  logic [CNT_W-1:0] rh_val;
  logic [CNT_W-1:0] rm_val;
  logic [CNT_W-1:0] wh_val;
  logic [CNT_W-1:0] wm_val;

  if (USE_CTRL_CNT) begin : g_cnt
    // Index order: 0 read_hit, 1 read_miss, 2 write_hit, 3 write_miss.
    logic [CNT_W-1:0] cnt_q [4];
    logic             cnt_en_q;
    logic             sat_q;
    logic [3:0]       ev;
    logic [CNT_W:0]   hit_sum;
    logic [CNT_W:0]   miss_sum;

    assign ev = {write_miss_i, write_hit_i, read_miss_i, read_hit_i};

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_en_q <= 1'b1;
        sat_q    <= 1'b0;
        for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else if (cke_i) begin
        if (ctrl_wr) cnt_en_q <= wdata_i[0];
        // A clear wins over any event in the same cycle; that event is lost.
        if (cnt_clr) begin
          sat_q <= 1'b0;
          for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else if (cnt_en_q) begin
          for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
              if (cnt_q[i] == CNT_MAX) begin
                if (SATURATE) sat_q <= 1'b1;
                else          cnt_q[i] <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
              end
            end
          end
        end
      end
    end

    // One extra bit catches the carry so the sums can clamp when saturating.
    assign hit_sum  = {1'b0, cnt_q[0]} + {1'b0, cnt_q[2]};
    assign miss_sum = {1'b0, cnt_q[1]} + {1'b0, cnt_q[3]};

    assign hit_val  = (SATURATE && hit_sum[CNT_W])  ? CNT_MAX : hit_sum[CNT_W-1:0];
    assign miss_val = (SATURATE && miss_sum[CNT_W]) ? CNT_MAX : miss_sum[CNT_W-1:0];
    assign rh_val   = cnt_q[0];
    assign rm_val   = cnt_q[1];
    assign wh_val   = cnt_q[2];
    assign wm_val   = cnt_q[3];
    assign cnt_en   = cnt_en_q;
    assign sat_flag = SATURATE ? sat_q : 1'b0;
  end else begin : g_no_cnt
    logic unused_cnt;
    assign unused_cnt = ^{read_hit_i, read_miss_i, write_hit_i, write_miss_i,
                          wdata_i[1:0], cnt_clr};
    assign hit_val  = '0;
    assign miss_val = '0;
    assign rh_val   = '0;
    assign rm_val   = '0;
    assign wh_val   = '0;
    assign wm_val   = '0;
    assign cnt_en   = 1'b0;
    assign sat_flag = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Invalidation FSM
  // --------------------------------------------------------------------------
  inval_state_t state_q;
  inval_state_t state_d;
  logic         invalidate_d;

  always_ff @(posedge clk_i) begin
    if (rst_i)      state_q <= S_IDLE;
    else if (cke_i) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (inval_req)         state_d = S_BUSY;
      S_BUSY:  if (invalidate_done_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // invalidate_o rises the cycle after BUSY is entered and falls in the cycle
  // right after invalidate_done_i is sampled, so it is high only while the
  // FSM was and remains BUSY across the edge.
  always_comb begin
    invalidate_d = (state_q == S_BUSY) && (state_d == S_BUSY);
  end

  assign inval_busy_o = (state_q == S_BUSY);

  // --------------------------------------------------------------------------
  // Read mux and registered response
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (word)
      W_HIT:        rd_word = DATA_W'(hit_val);
      W_MISS:       rd_word = DATA_W'(miss_val);
      W_READ_HIT:   rd_word = DATA_W'(rh_val);
      W_READ_MISS:  rd_word = DATA_W'(rm_val);
      W_WRITE_HIT:  rd_word = DATA_W'(wh_val);
      W_WRITE_MISS: rd_word = DATA_W'(wm_val);
      W_CTRL:       rd_word[0] = cnt_en;
      W_STATUS:     rd_word[3:0] = {sat_flag, inval_busy_o, wtbuf_full_i, wtbuf_empty_i};
      W_VERSION:    rd_word = CSR_VERSION;
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o      <= 1'b0;
      rdata_o      <= '0;
      invalidate_o <= 1'b0;
    end else if (cke_i) begin
      ready_o      <= valid_i;
      rdata_o      <= (valid_i && !is_write) ? rd_word : '0;
      invalidate_o <= invalidate_d;
    end
  end

endmodule

// File: tb/tb_iob_cache_perf_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iob_cache_perf_ctrl
//   Two instances with 4-bit counters (wrapping and saturating) share one
//   stimulus stream. A behavioural model counts raw events as plain integers
//   and derives the visible counter values by modulo / clamp, and a compare
//   process checks every output of both instances on every cycle. Directed
//   scenarios add literal expectations computed by hand.
// ----------------------------------------------------------------------------
module tb_iob_cache_perf_ctrl;

  localparam logic [31:0] VERSION = 32'h0000_0100;

  // clock / reset
  logic clk;
  logic rst;
  logic cke;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic        valid;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rh, rm, wh, wm;
  logic        wt_full, wt_empty;
  logic        inv_done;

  // DUT outputs
  logic [31:0] rdata_w, rdata_s;
  logic        ready_w, ready_s;
  logic        inval_w, inval_s;
  logic        busy_w, busy_s;

  iob_cache_perf_ctrl #(
    .DATA_W(32), .ADDR_W(6), .CNT_W(4), .SATURATE(1'b0), .USE_CTRL_CNT(1'b1)
  ) dut_w (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .valid_i(valid), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .wtbuf_full_i(wt_full), .wtbuf_empty_i(wt_empty),
    .invalidate_done_i(inv_done),
    .rdata_o(rdata_w), .ready_o(ready_w), .invalidate_o(inval_w),
    .inval_busy_o(busy_w)
  );

  iob_cache_perf_ctrl #(
    .DATA_W(32), .ADDR_W(6), .CNT_W(4), .SATURATE(1'b1), .USE_CTRL_CNT(1'b1)
  ) dut_s (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .valid_i(valid), .addr_i(addr),
    .wdata_i(wdata), .wstrb_i(wstrb),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .wtbuf_full_i(wt_full), .wtbuf_empty_i(wt_empty),
    .invalidate_done_i(inv_done),
    .rdata_o(rdata_s), .ready_o(ready_s), .invalidate_o(inval_s),
    .inval_busy_o(busy_s)
  );

  // --------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  //   raw[k] = events accepted since the last clear (0 rh, 1 rm, 2 wh, 3 wm).
  //   A 4-bit wrapping counter shows raw % 16; a saturating one shows
  //   min(raw, 15) and its sticky flag is set once any raw exceeded 15.
  // --------------------------------------------------------------------------
  int          raw [4];
  bit          m_en;
  bit          m_busy;
  logic        exp_ready;
  logic        exp_inval;
  logic [31:0] exp_rd_w;
  logic [31:0] exp_rd_s;

  function automatic logic [31:0] val(input int x, input bit s);
    if (s) return (x > 15) ? 32'd15 : 32'(x);
    return 32'(x % 16);
  endfunction

  function automatic logic [31:0] mread(input int w, input bit s);
    bit over;
    over = 1'b0;
    for (int k = 0; k < 4; k++) if (raw[k] > 15) over = 1'b1;
    case (w)
      0:       return val(raw[0] + raw[2], s);
      1:       return val(raw[1] + raw[3], s);
      2, 3, 4, 5: return val(raw[w-2], s);
      6:       return {31'b0, m_en};
      7:       return {28'b0, s && over, m_busy, wt_full, wt_empty};
      8:       return VERSION;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    int  w;
    bit  isw;
    bit  ctrl;
    if (rst) begin
      for (int k = 0; k < 4; k++) raw[k] = 0;
      m_en      = 1'b1;
      m_busy    = 1'b0;
      exp_ready = 1'b0;
      exp_inval = 1'b0;
      exp_rd_w  = '0;
      exp_rd_s  = '0;
    end else if (cke) begin
      w    = int'(addr[5:2]);
      isw  = |wstrb;
      ctrl = valid && isw && (w == 6) && wstrb[0];
      exp_ready = valid;
      exp_rd_w  = (valid && !isw) ? mread(w, 1'b0) : 32'h0;
      exp_rd_s  = (valid && !isw) ? mread(w, 1'b1) : 32'h0;
      if (m_busy) begin
        if (inv_done) m_busy = 1'b0;
        exp_inval = m_busy;
      end else begin
        exp_inval = 1'b0;
        if (ctrl && wdata[2]) m_busy = 1'b1;
      end
      if (ctrl && wdata[1]) begin
        for (int k = 0; k < 4; k++) raw[k] = 0;
      end else if (m_en) begin
        raw[0] += int'(rh);
        raw[1] += int'(rm);
        raw[2] += int'(wh);
        raw[3] += int'(wm);
      end
      if (ctrl) m_en = wdata[0];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ready_w", ready_w, exp_ready);
      check("ready_s", ready_s, exp_ready);
      check("rdata_w", rdata_w, exp_rd_w);
      check("rdata_s", rdata_s, exp_rd_s);
      check("inval_w", inval_w, exp_inval);
      check("inval_s", inval_s, exp_inval);
      check("busy_w",  busy_w,  m_busy);
      check("busy_s",  busy_s,  m_busy);
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (inputs change only at the falling edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; addr = 6'(w * 4); wdata = d; wstrb = s;
    tick();
    valid = 1'b0; wdata = '0; wstrb = '0;
  endtask

  task automatic rd(input int w, input logic [31:0] ew, input logic [31:0] es, input string nm);
    valid = 1'b1; addr = 6'(w * 4); wstrb = '0;
    tick();
    valid = 1'b0;
    check({nm, "_rdy"}, ready_w, 1'b1);
    check({nm, "_w"}, rdata_w, ew);
    check({nm, "_s"}, rdata_s, es);
  endtask

  task automatic ev(input bit a, input bit b, input bit c, input bit d);
    rh = a; rm = b; wh = c; wm = d;
    tick();
    rh = 1'b0; rm = 1'b0; wh = 1'b0; wm = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1; cke = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    rh = 1'b0; rm = 1'b0; wh = 1'b0; wm = 1'b0;
    wt_full = 1'b0; wt_empty = 1'b0; inv_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst_ready", ready_w, 1'b0);
    check("rst_rdata", rdata_s, 32'h0);
    check("rst_inval", inval_w, 1'b0);

    // Independent counters, simultaneous strobes.
    repeat (3) ev(1, 0, 0, 0);
    repeat (2) ev(0, 0, 0, 1);
    ev(1, 1, 1, 1);
    rd(2, 4, 4, "read_hit");
    rd(3, 1, 1, "read_miss");
    rd(4, 1, 1, "write_hit");
    rd(5, 3, 3, "write_miss");
    rd(0, 5, 5, "hit_sum");
    rd(1, 4, 4, "miss_sum");
    rd(6, 1, 1, "ctrl_rst");
    wr(2, 32'hFFFF_FFFF, 4'hF);
    rd(2, 4, 4, "cnt_wr_ignored");
    wr(6, 32'h0, 4'h2);
    rd(6, 1, 1, "ctrl_no_lane0");
    rd(9, 0, 0, "unmapped");
    rd(7, 0, 0, "status_idle");

    // Disable, then clear with a same-cycle event.
    wr(6, 32'h0, 4'hF);
    rd(6, 0, 0, "ctrl_dis");
    repeat (5) ev(1, 0, 0, 0);
    rd(2, 4, 4, "no_count_dis");
    valid = 1'b1; addr = 6'(6 * 4); wdata = 32'h3; wstrb = 4'hF; rh = 1'b1;
    tick();
    valid = 1'b0; wdata = '0; wstrb = '0; rh = 1'b0;
    for (int w = 0; w < 6; w++) rd(w, 0, 0, "clr_cnt");
    rd(6, 1, 1, "clr_en");

    // Overflow: wrap versus clamp.
    repeat (17) ev(1, 0, 0, 0);
    rd(2, 1, 15, "ovf_rh");
    rd(0, 1, 15, "ovf_hit");
    rd(7, 0, 8, "ovf_status");
    wr(6, 32'h3, 4'hF);
    rd(7, 0, 0, "sat_cleared");
    rd(2, 0, 0, "ovf_cleared");

    // Back-to-back reads of STATUS, VERSION, unmapped.
    wt_empty = 1'b1;
    valid = 1'b1; addr = 6'(7 * 4);
    tick();
    addr = 6'(8 * 4);
    check("b2b0_rdy", ready_w, 1'b1);
    check("b2b0_w", rdata_w, 32'h1);
    tick();
    addr = 6'(9 * 4);
    check("b2b1_rdy", ready_s, 1'b1);
    check("b2b1_s", rdata_s, VERSION);
    tick();
    valid = 1'b0;
    check("b2b2_rdy", ready_w, 1'b1);
    check("b2b2_w", rdata_w, 32'h0);
    tick();
    check("b2b_end", ready_w, 1'b0);
    wt_full = 1'b1;
    rd(7, 3, 3, "status_wtbuf");
    wt_full = 1'b0; wt_empty = 1'b0;

    // Invalidation handshake.
    wr(6, 32'h5, 4'hF);
    check("inv_lat1", inval_w, 1'b0);
    tick();
    check("inv_lat2", inval_w, 1'b1);
    rd(7, 4, 4, "status_busy");
    wr(6, 32'h5, 4'hF);
    tick();
    check("inv_hold", inval_s, 1'b1);
    inv_done = 1'b1;
    tick();
    inv_done = 1'b0;
    check("inv_drop", inval_w, 1'b0);
    rd(7, 0, 0, "status_idle2");
    repeat (2) tick();
    check("inv_not_queued", inval_w, 1'b0);
    inv_done = 1'b1;
    tick();
    inv_done = 1'b0;
    tick();
    check("done_idle", busy_w, 1'b0);

    // Clock enable low mid-request with events pulsing.
    cke = 1'b0; valid = 1'b1; addr = 6'(2 * 4); rh = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cke_hold_rdy", ready_w, 1'b0);
    end
    cke = 1'b1; rh = 1'b0;
    tick();
    valid = 1'b0;
    check("cke_rdy", ready_w, 1'b1);
    check("cke_no_cnt", rdata_w, 32'h0);
    valid = 1'b1; addr = 6'(6 * 4);
    tick();
    valid = 1'b0; cke = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cke_held_rdy", ready_s, 1'b1);
      check("cke_held_data", rdata_s, 32'h1);
    end
    cke = 1'b1;
    tick();
    check("cke_release", ready_w, 1'b0);

    // Reset while BUSY, with a pending request and clock enable low.
    wr(6, 32'h5, 4'hF);
    tick();
    check("rb_inv_on", inval_w, 1'b1);
    valid = 1'b1; addr = 6'(8 * 4); rst = 1'b1; cke = 1'b0;
    tick();
    rst = 1'b0; valid = 1'b0; cke = 1'b1;
    check("rb_inv_off", inval_w, 1'b0);
    check("rb_ready", ready_s, 1'b0);
    tick();
    check("rb_no_ready", ready_w, 1'b0);
    rd(6, 1, 1, "rb_ctrl");

    repeat (2) tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iob_cache_perf_ctrl.md
IOB_CACHE_PERF_CTRL -- requirements
Module: iob_cache_perf_ctrl

Interface
REQ-001 Parameter DATA_W, 32, CSR data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, 6, CSR byte-address width; SHALL be at least 6.
REQ-003 Parameter CNT_W, 32, event counter width; SHALL be 1..DATA_W; read data SHALL be zero-extended to DATA_W.
REQ-004 Parameter SATURATE, 0, counter overflow mode: 0 wrap, 1 clamp at all-ones.
REQ-005 Parameter USE_CTRL_CNT, 1; 0 SHALL remove all counter logic.
REQ-006 Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-007 clk_i  in  1  clock.
REQ-008 cke_i  in  1  clock enable; low SHALL hold every register, including outputs.
REQ-009 rst_i  in  1  synchronous active-high reset.
REQ-010 valid_i  in  1  CSR request.
REQ-011 addr_i  in  ADDR_W  byte address; word index is addr_i[ADDR_W-1:2].
REQ-012 wdata_i  in  DATA_W  write data.
REQ-013 wstrb_i  in  DATA_W/8  byte strobes; all zero means read.
REQ-014 read_hit_i, read_miss_i, write_hit_i, write_miss_i  in  1 each  single-cycle event strobes.
REQ-015 wtbuf_full_i, wtbuf_empty_i  in  1 each  write-through buffer status.
REQ-016 invalidate_done_i  in  1  cache invalidation complete.
REQ-017 rdata_o  out  DATA_W  read data.
REQ-018 ready_o  out  1  request acknowledge.
REQ-019 invalidate_o  out  1  invalidate request, level.

Function
REQ-020 Word map: 0 HIT, 1 MISS, 2 READ_HIT, 3 READ_MISS, 4 WRITE_HIT, 5 WRITE_MISS, 6 CTRL, 7 STATUS, 8 VERSION; all other words read 0 and ignore writes.
REQ-021 ready_o SHALL be 1 exactly one enabled cycle after each cycle with valid_i=1; back-to-back requests SHALL each receive a ready pulse.
REQ-022 rdata_o SHALL be valid in the ready_o cycle and 0 in every other cycle.
REQ-023 All four event counters SHALL update independently; simultaneous strobes SHALL each count in the same cycle.
REQ-024 Counters SHALL increment only when CTRL.cnt_en (bit0) is 1.
REQ-025 SATURATE=0: a counter at all-ones SHALL wrap to 0; SATURATE=1: it SHALL stay at all-ones and set the sticky STATUS.sat flag.
REQ-026 HIT SHALL read READ_HIT+WRITE_HIT, and MISS SHALL read READ_MISS+WRITE_MISS; each sum is CNT_W wide, truncated when SATURATE=0 and clamped when SATURATE=1.
REQ-027 A CTRL write is accepted only when wstrb_i[0]=1: bit0 sets cnt_en, bit1=1 clears all counters and STATUS.sat, and bit2=1 requests invalidation.
REQ-028 CTRL bits 1 and 2 SHALL be self-clearing and SHALL read 0.
REQ-029 A counter clear takes effect at the next edge and SHALL override any same-cycle event, which is lost.
REQ-030 Writes to words 0-5, 7 and 8 SHALL be ignored.
REQ-031 STATUS: bit0 wtbuf_empty_i, bit1 wtbuf_full_i, bit2 inval_busy, bit3 sat; all other bits 0.
REQ-032 VERSION SHALL read the codebase CSR version constant.
REQ-033 Invalidation FSM, state IDLE: a CTRL bit2 write moves it to BUSY, and invalidate_o=1 from the following cycle.
REQ-034 Invalidation FSM, state BUSY: invalidate_o held at 1; when invalidate_done_i=1 is sampled, go to IDLE and drop invalidate_o the next cycle.
REQ-035 A bit2 write while BUSY SHALL be ignored and not queued.
REQ-036 invalidate_done_i while IDLE SHALL be ignored.
REQ-037 USE_CTRL_CNT=0: words 0-5 read 0, CTRL bits 0-1 read/act as 0, STATUS.sat reads 0, and invalidation is unaffected.

Reset
REQ-038 rst_i=1 at an edge SHALL set counters to 0, sat to 0, cnt_en to 1, FSM to IDLE, and ready_o, rdata_o and invalidate_o to 0, regardless of cke_i.
REQ-039 Reset during BUSY SHALL abort invalidation, with invalidate_o=0 the next cycle; a request pending at reset SHALL receive no ready_o.

Verification
REQ-040 3 read_hit strobes and 2 write_miss strobes, plus one cycle with all four strobes -> READ_HIT=4, WRITE_HIT=1, READ_MISS=1, WRITE_MISS=3, HIT=5, MISS=4.
REQ-041 CNT_W=4, SATURATE=0, 17 read_hit -> READ_HIT=1, sat=0; with SATURATE=1 -> READ_HIT=15, STATUS=0x8 (wtbuf inputs 0).
REQ-042 Write CTRL=0x0, then 5 events, then CTRL=0x3 in the same cycle as a read_hit -> all counters 0 and cnt_en=1.
REQ-043 Write CTRL=0x5 -> invalidate_o high 2 cycles later; second bit2 write ignored; STATUS bit2=1; invalidate_done_i pulse -> invalidate_o low next cycle.
REQ-044 Back-to-back reads of words 7, 8, 9 with wtbuf_empty_i=1 -> ready_o high 3 consecutive cycles with rdata 0x1, VERSION, 0.
REQ-045 cke_i=0 for 3 cycles mid-request with events pulsing -> no counter change and ready_o delayed; rst_i in BUSY -> invalidate_o=0 next cycle.
